// File: rtl/key_search_ctrl.sv
// key_search_ctrl: brute-force key search sequencer around a single-key decrypt core.
// Keys 0..MAX_KEY are launched in order until a plaintext decodes to all-printable ASCII.

module key_search_byte_chk (
    input  logic [7:0] data,
    output logic       ok
);
    assign ok = (data >= 8'h20) && (data <= 8'h7E);
endmodule

module key_search_ctrl #(
    parameter int unsigned          KEY_WIDTH      = 24,
    parameter logic [KEY_WIDTH-1:0] MAX_KEY        = {KEY_WIDTH{1'b1}},
    parameter int unsigned          TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [127:0]         ciphertext_in,
    output logic                 dec_start,
    output logic [KEY_WIDTH-1:0] dec_key,
    output logic [127:0]         dec_ciphertext,
    input  logic                 dec_done,
    input  logic [127:0]         dec_plaintext,
    output logic [KEY_WIDTH-1:0] key,
    output logic [127:0]         plaintext,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam int NUM_LANES = 16;
    localparam int VEC_W     = 8;
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
    // Timeout is measured from the dec_start cycle, so WAIT gives up one count early.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, WAIT, CHECK} state_t;

    state_t                          state;
    logic [KEY_WIDTH-1:0]            key_cnt;
    logic [TW-1:0]                   tmo_cnt;
    logic [NUM_LANES-1:0][VEC_W-1:0] pt_cap;
    logic [NUM_LANES-1:0]            lane_ok;
    logic                            all_ok;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            key_search_byte_chk u_chk (
                .data (pt_cap[g]),
                .ok   (lane_ok[g])
            );
        end
    endgenerate

    assign all_ok  = &lane_ok;
    assign key     = key_cnt;
    assign dec_key = key_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            key_cnt        <= '0;
            tmo_cnt        <= '0;
            pt_cap         <= '0;
            dec_start      <= 1'b0;
            dec_ciphertext <= '0;
            plaintext      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            dec_start <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
                error <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state          <= LOAD;
                            busy           <= 1'b1;
                            done           <= 1'b0;
                            error          <= 1'b0;
                            plaintext      <= '0;
                            dec_ciphertext <= ciphertext_in;
                            key_cnt        <= '0;
                        end
                    end
                    LOAD: begin
                        state     <= LAUNCH;
                        dec_start <= 1'b1;
                    end
                    LAUNCH: begin
                        state   <= WAIT;
                        tmo_cnt <= '0;
                    end
                    WAIT: begin
                        if (dec_done) begin
                            pt_cap <= dec_plaintext;
                            state  <= CHECK;
                        end else if (tmo_cnt == TMO_LAST) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (all_ok) begin
                            plaintext <= pt_cap;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else if (key_cnt == MAX_KEY) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            // dec_start rises together with the new key so both are seen in LAUNCH
                            key_cnt   <= key_cnt + 1'b1;
                            dec_start <= 1'b1;
                            state     <= LAUNCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_key_search_ctrl.sv
// Randomized scoreboard bench for key_search_ctrl with a behavioural 4-cycle decrypt core.
// Expected search results come from a plain loop over the key space.

module tb_key_search_ctrl;
    localparam int            KW   = 24;
    localparam logic [KW-1:0] MAXK = 24'd15;
    localparam int            TMO  = 16;
    localparam int            LAT  = 4;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [127:0]  ciphertext_in;
    logic          dec_start;
    logic [KW-1:0] dec_key;
    logic [127:0]  dec_ciphertext;
    logic          dec_done;
    logic [127:0]  dec_plaintext;
    logic [KW-1:0] key;
    logic [127:0]  plaintext;
    logic          busy, done, error;

    key_search_ctrl #(.KEY_WIDTH(KW), .MAX_KEY(MAXK), .TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .ciphertext_in  (ciphertext_in),
        .dec_start      (dec_start),
        .dec_key        (dec_key),
        .dec_ciphertext (dec_ciphertext),
        .dec_done       (dec_done),
        .dec_plaintext  (dec_plaintext),
        .key            (key),
        .plaintext      (plaintext),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            done_e;
        bit            err_e;
        logic [KW-1:0] key_e;
        logic [127:0]  pt_e;
        int            launches_e;
        bit            tmo_e;
    } exp_t;

    exp_t         sb_q[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           launches = 0;
    int           last_launch = 0;
    logic [127:0] cur_ct = '0;
    bit           core_mute = 1'b0;

    // Key is scrambled before the XOR so neighbouring keys do not all decode to text.
    function automatic logic [127:0] kstream(input logic [KW-1:0] k);
        logic [KW-1:0] m;
        logic [143:0]  r;
        m = k * 24'h9E3779;
        r = {6{m}};
        return r[127:0];
    endfunction

    function automatic bit printable(input logic [127:0] p);
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = p[8*i +: 8];
            if (b < 8'h20 || b > 8'h7E) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic exp_t model_search(input logic [127:0] ct, input bit mute);
        exp_t e;
        e.done_e = 0; e.err_e = 1; e.key_e = '0; e.pt_e = '0; e.launches_e = 1; e.tmo_e = mute;
        if (mute) return e;
        for (int k = 0; k <= int'(MAXK); k++) begin
            e.launches_e = k + 1;
            e.key_e      = KW'(k);
            if (printable(ct ^ kstream(KW'(k)))) begin
                e.done_e = 1; e.err_e = 0; e.pt_e = ct ^ kstream(KW'(k));
                return e;
            end
        end
        return e;
    endfunction

    // Bytes 0 and 3 see the same keystream byte; a 0x80 difference means one is always >= 0x80.
    function automatic logic [127:0] bad_ct();
        logic [127:0] c;
        c = {$urandom, $urandom, $urandom, $urandom};
        c[31:24] = c[7:0] ^ 8'h80;
        return c;
    endfunction

    function automatic logic [127:0] good_ct(input logic [KW-1:0] t);
        logic [127:0] p;
        for (int i = 0; i < 16; i++) p[8*i +: 8] = 8'($urandom_range(32, 126));
        return p ^ kstream(t);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin : core
        int lat;
        logic [127:0] core_pt;
        dec_done <= 1'b0;
        if (dec_start && !core_mute) begin
            lat     = LAT - 1;
            core_pt = dec_ciphertext ^ kstream(dec_key);
        end else if (lat > 0) begin
            if (lat == 1) begin
                dec_done      <= 1'b1;
                dec_plaintext <= core_pt;
            end
            lat = lat - 1;
        end
    end

    initial begin : monitor
        exp_t e;
        bit   prev_busy;
        prev_busy = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_busy = 0;
                launches  = 0;
            end else begin
                if (dec_start) begin
                    check("dec_key", dec_key, KW'(launches));
                    check("dec_ciphertext", dec_ciphertext, cur_ct);
                    launches++;
                    last_launch = cyc;
                end
                if (prev_busy && !busy) begin
                    if (sb_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_end: busy fell with no search pending");
                    end else begin
                        e = sb_q.pop_front();
                        check("done", done, e.done_e);
                        check("error", error, e.err_e);
                        check("key", key, e.key_e);
                        check("plaintext", plaintext, e.pt_e);
                        check("launches", launches, e.launches_e);
                        if (e.tmo_e) check("timeout_cycles", cyc - last_launch, TMO);
                    end
                    launches = 0;
                end
                prev_busy = busy;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL search_timeout: no completion after %0d cycles", n);
            sb_q.delete();
            @(posedge clk); #1 abort = 1;
            @(posedge clk); #1 abort = 0;
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic issue_start(input logic [127:0] ct);
        @(posedge clk); #1;
        start = 1; ciphertext_in = ct; cur_ct = ct;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic run_search(input logic [127:0] ct, input bit mute, input bit poke);
        exp_t e;
        e = model_search(ct, mute);
        core_mute = mute;
        sb_q.push_back(e);
        issue_start(ct);
        @(negedge clk);
        check("busy_after_start", busy, 1'b1);
        check("no_early_launch", dec_start, 1'b0);
        @(negedge clk);
        check("first_launch", dec_start, 1'b1);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1 start = 1; ciphertext_in = ~ct;
            @(posedge clk); #1 start = 0;
        end
        wait_idle();
        check("done_hold", done, e.done_e);
        check("error_hold", error, e.err_e);
        check("key_hold", key, e.key_e);
    endtask

    task automatic run_abort(input logic [127:0] ct, input int at_key, input int dly);
        exp_t e;
        int   n;
        e.done_e = 0; e.err_e = 0; e.key_e = KW'(at_key); e.pt_e = '0;
        e.launches_e = at_key + 1; e.tmo_e = 0;
        core_mute = 0;
        sb_q.push_back(e);
        issue_start(ct);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dec_start && dec_key == KW'(at_key)) && n < 600);
        repeat (dly) @(posedge clk);
        #1 abort = 1; start = 1;
        @(posedge clk); #1 abort = 0; start = 0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        wait_idle();
        check("abort_no_done", done, 1'b0);
        check("abort_no_error", error, 1'b0);
        check("abort_no_launch", launches, 0);
    endtask

    task automatic run_reset(input int dly);
        core_mute = 0;
        issue_start(bad_ct());
        repeat (dly) @(posedge clk);
        #3 rst = 0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_dec_start", dec_start, 1'b0);
        check("rst_key", key, '0);
        check("rst_plaintext", plaintext, '0);
        check("rst_dec_ct", dec_ciphertext, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        repeat (12) @(negedge clk);
        check("post_rst_idle", busy, 1'b0);
        check("post_rst_launch", launches, 0);
    endtask

    initial begin : stim
        logic [127:0] hello;
        rst = 0; start = 0; abort = 0; ciphertext_in = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_error", error, 1'b0);
        check("reset_dec_start", dec_start, 1'b0);
        check("reset_key", key, '0);
        check("reset_plaintext", plaintext, '0);
        check("reset_dec_key", dec_key, '0);
        check("reset_dec_ct", dec_ciphertext, '0);
        @(posedge clk); #1 rst = 1;
        repeat (10) @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_launch", launches, 0);

        hello = "HELLO WORLD!!!!!";
        run_search(hello ^ kstream(24'd5), 0, 0);
        check("hello_key", key, 24'd5);
        check("hello_plaintext", plaintext, hello);

        run_search(bad_ct(), 0, 0);
        check("exhaust_key", key, 24'h00000F);
        check("exhaust_error", error, 1'b1);
        check("exhaust_plaintext", plaintext, '0);

        run_abort(bad_ct(), 3, 2);
        run_search(good_ct(24'd9), 0, 1);
        run_search({$urandom, $urandom, $urandom, $urandom}, 1, 0);
        check("timeout_error", error, 1'b1);
        run_reset(7);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0: run_search(good_ct(KW'($urandom_range(0, 15))), 0, 1'($urandom_range(0, 1)));
                1: run_search(bad_ct(), 0, 0);
                2: run_search(bad_ct(), 1, 0);
                3: run_abort(bad_ct(), $urandom_range(0, 5), $urandom_range(1, 4));
                4: run_reset($urandom_range(2, 40));
                default: run_search({$urandom, $urandom, $urandom, $urandom}, 0, 1);
            endcase
        end

        repeat (10) @(negedge clk);
        check("final_idle_launch", launches, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
